// File: rtl/smem_pkg.sv
// rtl/smem_pkg.sv - shared line width, FSM states and trailer magic for the SMEM result writer
package smem_pkg;

    localparam int LINE_W = 512;
    localparam logic [31:0] TRAILER_MAGIC = 32'h534D454D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } smem_state_e;

endpackage

// File: rtl/smem_line_fifo.sv
// rtl/smem_line_fifo.sv - show-ahead line FIFO with occupancy count; push to full is legal only alongside a pop
module smem_line_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 512,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/smem_result_writer.sv
// rtl/smem_result_writer.sv - buffers streamed result lines and writes them to consecutive host lines
// Optional completion trailer write enabled by SMEM_RESULT_TRAILER_EN.
module smem_result_writer
    import smem_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 58,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              job_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              output_request,
    output logic              output_permit,
    input  logic [LINE_W-1:0] output_data,
    input  logic              output_valid,
    input  logic              output_finish,
    output logic              stall,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              job_done,
    output logic [CNT_W-1:0]  lines_written,
    output logic              err_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 2);

    smem_state_e       state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0]  lines_q;
    logic              stall_q;
    logic              err_q;

    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LINE_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              push_acc;
    logic              drain_done;

    assign push     = (state_q == ST_STREAM) && output_valid;
    assign pop      = !fifo_empty && wr_ready;
    assign push_acc = push && (!fifo_full || pop);
    // Stall tracks the occupancy the FIFO will hold after this edge, leaving room for one in-flight line.
    assign count_d  = fifo_count + CW'(push_acc) - CW'(pop);

    smem_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LINE_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (output_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef SMEM_RESULT_TRAILER_EN
    logic              trailer_q;
    logic              trailer_vld;
    logic [LINE_W-1:0] trailer_line;

    assign trailer_vld = (state_q == ST_DRAIN) && fifo_empty && !trailer_q;

    always_comb begin
        trailer_line              = '0;
        trailer_line[CNT_W-1:0]   = lines_q;
        trailer_line[63:32]       = TRAILER_MAGIC;
    end

    assign wr_valid   = !fifo_empty || trailer_vld;
    assign wr_data    = !fifo_empty ? fifo_head : (trailer_vld ? trailer_line : '0);
    assign drain_done = fifo_empty && trailer_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trailer_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && job_start) begin
            trailer_q <= 1'b0;
        end else if (trailer_vld && wr_ready) begin
            trailer_q <= 1'b1;
        end
    end
`else
    assign wr_valid   = !fifo_empty;
    assign wr_data    = fifo_empty ? '0 : fifo_head;
    assign drain_done = fifo_empty;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            lines_q  <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stall_q <= (count_d >= STALL_LVL);
            if (push && fifo_full && !pop) err_q <= 1'b1;
            if (pop) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                lines_q  <= lines_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (job_start) begin
                        wr_ptr_q <= base_addr;
                        lines_q  <= '0;
                        state_q  <= ST_ARMED;
                    end
                end
                ST_ARMED:  if (output_request) state_q <= ST_STREAM;
                ST_STREAM: if (output_finish && !output_valid) state_q <= ST_DRAIN;
                ST_DRAIN:  if (drain_done) state_q <= ST_DONE;
                ST_DONE:   state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign output_permit = (state_q == ST_STREAM);
    assign job_done      = (state_q == ST_DONE);
    assign stall         = stall_q;
    assign wr_addr       = wr_ptr_q;
    assign lines_written = lines_q;
    assign err_overflow  = err_q;

endmodule
